// File: rtl/multiplier_control_if.sv
// rtl/multiplier_control_if.sv - control/handshake bundle between the multiplier sequencer and its datapath
interface multiplier_control_if #(
  parameter int WIDTH = 32
);
  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic             run;
  logic             prod_lsb;
  logic             ready;
  logic             mcand_w_ctrl;
  logic             prod_init;
  logic             prod_w_ctrl;
  logic             alu_add;
  logic             prod_srl;
  logic [CNT_W-1:0] iter_cnt;
  logic             done;

  // master: the sequencer; slave: the wrapper/datapath side
  modport master (
    input  run, prod_lsb,
    output ready, mcand_w_ctrl, prod_init, prod_w_ctrl, alu_add, prod_srl, iter_cnt, done
  );

  modport slave (
    output run, prod_lsb,
    input  ready, mcand_w_ctrl, prod_init, prod_w_ctrl, alu_add, prod_srl, iter_cnt, done
  );
endinterface

// File: rtl/multiplier_control.sv
// rtl/multiplier_control.sv - shift-add multiplier sequencer: load, WIDTH add/shift iterations, done pulse
module multiplier_control #(
  parameter int WIDTH = 32
) (
  input  logic                clk,
  input  logic                reset,
  multiplier_control_if.master bus
);
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ITER = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Counter is cleared on every non-ITER cycle so it is 0 on ITER entry and never wraps
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      IDLE: begin
        if (bus.run) state_d = LOAD;
      end
      LOAD: begin
        state_d = ITER;
      end
      ITER: begin
        if (cnt_q == LAST_ITER) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.ready        = 1'b0;
    bus.mcand_w_ctrl = 1'b0;
    bus.prod_init    = 1'b0;
    bus.prod_w_ctrl  = 1'b0;
    bus.alu_add      = 1'b0;
    bus.prod_srl     = 1'b0;
    bus.done         = 1'b0;
    bus.iter_cnt     = cnt_q;
    case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
      end
      LOAD: begin
        bus.mcand_w_ctrl = 1'b1;
        bus.prod_w_ctrl  = 1'b1;
        bus.prod_init    = 1'b1;
      end
      ITER: begin
        bus.prod_w_ctrl = 1'b1;
        bus.prod_srl    = 1'b1;
        bus.alu_add     = bus.prod_lsb;
      end
      DONE: begin
        bus.done = 1'b1;
      end
      default: begin
        bus.ready = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_multiplier_control.sv
// tb/tb_multiplier_control.sv - vector table plus corner sequences, datapath model and product scoreboard
module tb_multiplier_control;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multiplier_control_if #(.WIDTH(32)) bus32 ();
  multiplier_control_if #(.WIDTH(8))  bus8 ();

  multiplier_control #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  multiplier_control #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Datapath reference: multiplicand and product registers driven by the controller outputs
  logic [31:0] a32 = '0, b32 = '0, mcand32 = '0;
  logic [63:0] prod32 = '0;
  logic [32:0] sum32;
  logic [7:0]  a8 = '0, b8 = '0, mcand8 = '0;
  logic [15:0] prod8 = '0;
  logic [8:0]  sum8;

  assign sum32 = bus32.alu_add ? ({1'b0, prod32[63:32]} + {1'b0, mcand32}) : {1'b0, prod32[63:32]};
  assign sum8  = bus8.alu_add  ? ({1'b0, prod8[15:8]} + {1'b0, mcand8}) : {1'b0, prod8[15:8]};
  assign bus32.prod_lsb = prod32[0];
  assign bus8.prod_lsb  = prod8[0];

  always @(posedge clk) begin
    if (bus32.mcand_w_ctrl) mcand32 <= a32;
    if (bus32.prod_w_ctrl) begin
      if (bus32.prod_init)     prod32 <= {32'b0, b32};
      else if (bus32.prod_srl) prod32 <= 64'({sum32, prod32[31:0]} >> 1);
    end
    if (bus8.mcand_w_ctrl) mcand8 <= a8;
    if (bus8.prod_w_ctrl) begin
      if (bus8.prod_init)     prod8 <= {8'b0, b8};
      else if (bus8.prod_srl) prod8 <= 16'({sum8, prod8[7:0]} >> 1);
    end
  end

  logic [63:0] q32[$];
  logic [15:0] q8[$];

  always @(negedge clk) begin
    if (reset) begin
      chk("ctrl_invariant",
          64'((bus32.prod_init && bus32.prod_srl) || (bus32.mcand_w_ctrl && !bus32.prod_init) ||
              ((bus32.prod_init || bus32.prod_srl || bus32.alu_add) && !bus32.prod_w_ctrl) ||
              (bus32.done && bus32.prod_w_ctrl) || (bus32.ready && (bus32.prod_w_ctrl || bus32.done))),
          64'd0);
      if (bus32.done) begin
        if (q32.size() == 0) chk("unexpected_done32", 64'd1, 64'd0);
        else                 chk("product32", prod32, q32.pop_front());
      end
      if (bus8.done) begin
        if (q8.size() == 0) chk("unexpected_done8", 64'd1, 64'd0);
        else                chk("product8", 64'(prod8), 64'(q8.pop_front()));
      end
    end
  end

  // Follows one accepted multiply from the LOAD cycle up to its done pulse
  task automatic track(input logic [31:0] b, input bit noisy);
    int n = 0;
    int srl = 0;
    int mc = 0;
    logic [31:0] mask = '0;
    bit seen = 0;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (bus32.prod_srl) srl++;
      if (bus32.mcand_w_ctrl) mc++;
      if (bus32.alu_add) mask[bus32.iter_cnt[4:0]] = 1'b1;
      if (bus32.done) seen = 1;
      if (noisy && n == 12) bus32.run = 1'b1;
      if (noisy && n == 13) bus32.run = 1'b0;
    end
    chk("done_seen", 64'(seen), 64'd1);
    chk("done_latency", 64'(n), 64'd34);
    chk("srl_cycles", 64'(srl), 64'd32);
    chk("mcand_cycles", 64'(mc), 64'd1);
    chk("alu_add_mask", 64'(mask), 64'(b));
    if (noisy) begin
      bus32.run = 1'b1;
      @(posedge clk);
      #1 bus32.run = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("run_ignored_idle", 64'({bus32.ready, bus32.mcand_w_ctrl}), 64'b10);
      end
    end
  endtask

  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    a32 = a;
    b32 = b;
    @(negedge clk);
    bus32.run = 1'b1;
    @(posedge clk);
    q32.push_back(exp);
    #1 bus32.run = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n;
    int t;
    int d1;
    int d2;
    int mx;
    bit hit;

    vecs[0] = '{32'hFF00_F0F0, 32'h0000_5252, 64'(32'hFF00_F0F0) * 64'(32'h0000_5252)};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{32'h0000_0003, 32'h0000_0005, 64'd15};
    vecs[3] = '{32'h1234_5678, 32'h0000_0001, 64'h0000_0000_1234_5678};
    vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 64'd0};
    vecs[5] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};

    bus32.run = 1'b1;
    bus8.run  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(bus32.ready), 64'd1);
    chk("rst_done", 64'(bus32.done), 64'd0);
    chk("rst_writes", 64'({bus32.mcand_w_ctrl, bus32.prod_w_ctrl, bus32.prod_init,
                           bus32.prod_srl, bus32.alu_add}), 64'd0);
    chk("rst_iter_cnt", 64'(bus32.iter_cnt), 64'd0);

    a32 = 32'd7;
    b32 = 32'd9;
    reset = 1'b1;
    @(posedge clk);
    q32.push_back(64'd63);
    #1 bus32.run = 1'b0;
    chk("load_after_release", 64'(bus32.mcand_w_ctrl), 64'd1);
    track(32'd9, 1'b0);

    for (int i = 0; i < 6; i++) begin
      start32(vecs[i].a, vecs[i].b, vecs[i].exp);
      track(vecs[i].b, i == 2);
    end

    // Back-to-back with run held high
    a32 = 32'hFF00_F0F0;
    b32 = 32'h0000_5252;
    @(negedge clk);
    bus32.run = 1'b1;
    @(posedge clk);
    q32.push_back(64'(a32) * 64'(b32));
    t = 0;
    d1 = -100;
    d2 = -100;
    while (t < 200 && d2 < 0) begin
      @(negedge clk);
      t++;
      if (t == d1 + 1) chk("b2b_idle_ready", 64'(bus32.ready), 64'd1);
      if (t == d1 + 2) begin
        chk("b2b_second_load", 64'(bus32.mcand_w_ctrl), 64'd1);
        q32.push_back(64'(a32) * 64'(b32));
        bus32.run = 1'b0;
      end
      if (bus32.done) begin
        if (d1 < 0) d1 = t;
        else        d2 = t;
      end
    end
    bus32.run = 1'b0;
    chk("b2b_done_spacing", 64'(d2 - d1), 64'd35);

    // Asynchronous reset between edges at iteration 17
    start32(32'h1234_5678, 32'hDEAD_BEEF, 64'(32'h1234_5678) * 64'(32'hDEAD_BEEF));
    hit = 0;
    n = 0;
    while (n < 100 && !hit) begin
      @(negedge clk);
      n++;
      if (bus32.prod_srl && bus32.iter_cnt == 6'd17) hit = 1;
    end
    chk("reached_iter17", 64'(hit), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ready", 64'(bus32.ready), 64'd1);
    chk("async_rst_outs", 64'({bus32.mcand_w_ctrl, bus32.prod_w_ctrl, bus32.prod_init,
                               bus32.prod_srl, bus32.alu_add, bus32.done}), 64'd0);
    chk("async_rst_cnt", 64'(bus32.iter_cnt), 64'd0);
    if (q32.size() > 0) q32.pop_back();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 chk("post_rst_idle", 64'(bus32.ready), 64'd1);
    start32(32'h1234_5678, 32'hDEAD_BEEF, 64'(32'h1234_5678) * 64'(32'hDEAD_BEEF));
    track(32'hDEAD_BEEF, 1'b0);

    // WIDTH = 8 instance
    a8 = 8'hFF;
    b8 = 8'hFF;
    @(negedge clk);
    bus8.run = 1'b1;
    @(posedge clk);
    q8.push_back(16'hFE01);
    #1 bus8.run = 1'b0;
    n = 0;
    mx = 0;
    hit = 0;
    while (n < 50 && !hit) begin
      @(negedge clk);
      n++;
      if (bus8.prod_srl && int'(bus8.iter_cnt) > mx) mx = int'(bus8.iter_cnt);
      if (bus8.done) hit = 1;
    end
    chk("w8_done_latency", 64'(n), 64'd10);
    chk("w8_iter_max", 64'(mx), 64'd7);

    repeat (3) @(negedge clk);
    chk("scoreboard32_empty", 64'(q32.size()), 64'd0);
    chk("scoreboard8_empty", 64'(q8.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
